wb_queue: RTL

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue.sv | 130 +++++++++++++
 1 files changed

// File: rtl/wb_queue.sv
// Write-back queue: DEPTH-entry circular FIFO of {dst, val} feeding one registered
// register-file write port. Optional same-edge bypass when empty: WB_QUEUE_BYPASS_EN.
module wb_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_dst,
  input  logic [31:0]              in_val,
  input  logic                     wb_hold,
  input  logic                     flush,
  output logic                     wb_en,
  output logic [3:0]               wb_dst,
  output logic [31:0]              wb_val,
  output logic [14:0]              pending,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dropped_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [3:0]    dst_mem [DEPTH];
  logic [31:0]   val_mem [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wb_en_q, wb_en_d;
  logic [3:0]    wb_dst_q, wb_dst_d;
  logic [31:0]   wb_val_q, wb_val_d;
  logic          dropped_q, dropped_d;

  logic accept, is_pc, push, pop, bypass;

  always_comb begin
    in_ready = (count_q < CW'(DEPTH));
    accept   = in_valid & in_ready & ~flush;
    is_pc    = (in_dst == 4'd15);
    pop      = ~flush & ~wb_hold & (count_q != '0);
`ifdef WB_QUEUE_BYPASS_EN
    // Bypass only when nothing is queued, so ordering is preserved.
    bypass   = accept & ~is_pc & (count_q == '0) & ~wb_hold;
`else
    bypass   = 1'b0;
`endif
    push     = accept & ~is_pc & ~bypass;

    wb_en_d  = 1'b0;
    wb_dst_d = wb_dst_q;
    wb_val_d = wb_val_q;
    if (pop) begin
      wb_en_d  = 1'b1;
      wb_dst_d = dst_mem[rptr_q];
      wb_val_d = val_mem[rptr_q];
    end else if (bypass) begin
      wb_en_d  = 1'b1;
      wb_dst_d = in_dst;
      wb_val_d = in_val;
    end

    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end

    dropped_d = accept & is_pc;
  end

  // Entries are scanned from the head; only the first count_q slots are live.
  always_comb begin
    pending = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q) begin
        for (int unsigned r = 0; r < 15; r++) begin
          if (dst_mem[AW'(rptr_q + AW'(k))] == 4'(r)) pending[r] = 1'b1;
        end
      end
    end
    if (wb_en_q) begin
      for (int unsigned r = 0; r < 15; r++) begin
        if (wb_dst_q == 4'(r)) pending[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      wb_en_q   <= 1'b0;
      wb_dst_q  <= '0;
      wb_val_q  <= '0;
      dropped_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      wb_en_q   <= wb_en_d;
      wb_dst_q  <= wb_dst_d;
      wb_val_q  <= wb_val_d;
      dropped_q <= dropped_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dst_mem[wptr_q] <= in_dst;
      val_mem[wptr_q] <= in_val;
    end
  end

  assign wb_en      = wb_en_q;
  assign wb_dst     = wb_dst_q;
  assign wb_val     = wb_val_q;
  assign count      = count_q;
  assign dropped_pc = dropped_q;

endmodule
